// File: rtl/rob_pkg.sv
// Shared types and helpers for the multi-commit reorder buffer.
package rob_pkg;

   // Opcode field occupies inst[OP_RANGE-1:0].
   localparam int OP_RANGE = 7;
   localparam logic [OP_RANGE-1:0] BRANCH_OP = 7'b1100011;
   localparam logic [OP_RANGE-1:0] JALR_OP   = 7'b1100111;
   localparam logic [OP_RANGE-1:0] STORE_OP  = 7'b0100011;

   // Tag value meaning "no ROB entry".
   localparam int ZERO_ROB = 0;

   typedef enum logic [1:0] {
      CLS_ALU    = 2'd0,
      CLS_BRANCH = 2'd1,
      CLS_JALR   = 2'd2,
      CLS_STORE  = 2'd3
   } op_class_e;

   // Per-entry control state; wide payload fields live in separate arrays.
   typedef struct packed {
      logic      valid;
      logic      ready;
      logic      pred;
      logic      jump;
      op_class_e cls;
   } rob_meta_t;

   function automatic op_class_e decode_op(input logic [OP_RANGE-1:0] op);
      case (op)
         BRANCH_OP: return CLS_BRANCH;
         JALR_OP:   return CLS_JALR;
         STORE_OP:  return CLS_STORE;
         default:   return CLS_ALU;
      endcase
   endfunction

   // Tags run 1..depth and wrap back to 1.
   function automatic int wrap_inc(input int ptr, input int depth);
      return (ptr >= depth) ? 1 : ptr + 1;
   endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Combinational commit-lane picker: contiguous ready prefix from the head,
// closed by the first branch/JALR and by a second store.
module rob_commit_sel
   import rob_pkg::*;
#(
   parameter int COMMIT_W = 2,
   parameter int LANE_W   = 1
) (
   input  logic [COMMIT_W-1:0] lane_ready,
   input  op_class_e           lane_cls [COMMIT_W],
   output logic [COMMIT_W-1:0] lane_mask,
   output logic                ctrl_hit,
   output logic [LANE_W-1:0]   ctrl_lane,
   output logic                store_hit,
   output logic [LANE_W-1:0]   store_lane
);

   logic open_v;

   // Walk lanes in program order and stop at the first blocker.
   always_comb begin
      // NOTE: every output and temporary gets a default before any branch, so no latch is inferred.
      lane_mask  = '0;
      ctrl_hit   = 1'b0;
      ctrl_lane  = '0;
      store_hit  = 1'b0;
      store_lane = '0;
      open_v     = 1'b1;
      for (int i = 0; i < COMMIT_W; i++) begin
         if (open_v) begin
            if (!lane_ready[i] || (lane_cls[i] == CLS_STORE && store_hit)) begin
               open_v = 1'b0;
            end else begin
               lane_mask[i] = 1'b1;
               if (lane_cls[i] == CLS_STORE) begin
                  store_hit  = 1'b1;
                  store_lane = LANE_W'(i);
               end
               if (lane_cls[i] == CLS_BRANCH || lane_cls[i] == CLS_JALR) begin
                  ctrl_hit  = 1'b1;
                  ctrl_lane = LANE_W'(i);
                  open_v    = 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: rtl/rob_multi.sv
// Reorder buffer with N CDB write ports and up to COMMIT_W in-order commits
// per cycle; flushes itself on a branch mispredict or JALR commit.
module rob_multi
   import rob_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int TAG_W    = $clog2(DEPTH + 1),
   parameter int N_CDB    = 2,
   parameter int COMMIT_W = 2,
   parameter int DATA_W   = 32,
   parameter int REG_W    = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ena,
   input  logic                      alloc_valid,
   input  logic [DATA_W-1:0]         alloc_inst,
   input  logic [REG_W-1:0]          alloc_dest,
   input  logic [DATA_W-1:0]         alloc_pc,
   input  logic                      alloc_pred_taken,
   output logic [TAG_W-1:0]          alloc_tag,
   output logic                      full,
   input  logic [N_CDB*TAG_W-1:0]    cdb_tag,
   input  logic [N_CDB*DATA_W-1:0]   cdb_value,
   input  logic                      cdb_isjump,
   input  logic [DATA_W-1:0]         cdb_jump_addr,
   input  logic [TAG_W-1:0]          q_tag1,
   input  logic [TAG_W-1:0]          q_tag2,
   output logic                      q_ready1,
   output logic                      q_ready2,
   output logic [DATA_W-1:0]         q_value1,
   output logic [DATA_W-1:0]         q_value2,
   output logic [COMMIT_W-1:0]       cm_valid,
   output logic [COMMIT_W*REG_W-1:0] cm_reg,
   output logic [COMMIT_W*TAG_W-1:0] cm_tag,
   output logic [COMMIT_W*DATA_W-1:0] cm_value,
   output logic [TAG_W-1:0]          cm_store_tag,
   output logic                      fwd_ena,
   output logic [DATA_W-1:0]         fwd_pc,
   output logic                      fwd_taken,
   output logic                      misbranch,
   output logic [DATA_W-1:0]         correct_addr
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int LANE_W = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;

   rob_meta_t         meta_q [DEPTH], meta_d [DEPTH];
   logic [REG_W-1:0]  dest_q [DEPTH], dest_d [DEPTH];
   logic [DATA_W-1:0] pc_q [DEPTH], pc_d [DEPTH];
   logic [DATA_W-1:0] jaddr_q [DEPTH], jaddr_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH], data_d [DEPTH];
   logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d, count_q, count_d;

   logic [COMMIT_W-1:0]        cm_valid_q, cm_valid_d;
   logic [COMMIT_W*REG_W-1:0]  cm_reg_q, cm_reg_d;
   logic [COMMIT_W*TAG_W-1:0]  cm_tag_q, cm_tag_d;
   logic [COMMIT_W*DATA_W-1:0] cm_value_q, cm_value_d;
   logic [TAG_W-1:0]           cm_store_tag_q, cm_store_tag_d;
   logic                       fwd_ena_q, fwd_ena_d, fwd_taken_q, fwd_taken_d;
   logic                       misbranch_q, misbranch_d;
   logic [DATA_W-1:0]          fwd_pc_q, fwd_pc_d, correct_addr_q, correct_addr_d;

   logic [IDX_W-1:0]    head_idx, tail_idx, new_head_idx, pidx, cidx;
   logic [IDX_W-1:0]    lane_idx [COMMIT_W];
   logic [COMMIT_W-1:0] lane_ready, sel_mask;
   op_class_e           lane_cls [COMMIT_W];
   logic                ctrl_hit, store_hit, alloc_fire;
   logic [LANE_W-1:0]   ctrl_lane, store_lane;
   logic [TAG_W-1:0]    ptag, n_commit;
   logic                unused_inst;

   // Only the opcode field of the instruction word is needed after dispatch.
   assign unused_inst = ^alloc_inst[DATA_W-1:OP_RANGE];

   assign full       = (count_q == TAG_W'(DEPTH));
   assign alloc_tag  = full ? TAG_W'(ZERO_ROB) : tail_q;
   assign alloc_fire = alloc_valid && !full;

   // Gather the head-window entries that are candidates for commit.
   always_comb begin
      head_idx = IDX_W'(head_q - TAG_W'(1));
      tail_idx = IDX_W'(tail_q - TAG_W'(1));
      for (int i = 0; i < COMMIT_W; i++) begin
         lane_idx[i]   = head_idx + IDX_W'(i);
         lane_ready[i] = meta_q[lane_idx[i]].valid && meta_q[lane_idx[i]].ready;
         lane_cls[i]   = meta_q[lane_idx[i]].cls;
      end
   end

   rob_commit_sel #(.COMMIT_W(COMMIT_W), .LANE_W(LANE_W)) u_sel (
      .lane_ready (lane_ready),
      .lane_cls   (lane_cls),
      .lane_mask  (sel_mask),
      .ctrl_hit   (ctrl_hit),
      .ctrl_lane  (ctrl_lane),
      .store_hit  (store_hit),
      .store_lane (store_lane)
   );

   // Next state: CDB writes, commit, allocation, then flush overrides all.
   always_comb begin
      // NOTE: always_comb uses blocking assignments so later steps see earlier updates in the same pass.
      meta_d = meta_q;   dest_d = dest_q;   pc_d = pc_q;
      jaddr_d = jaddr_q; data_d = data_q;
      head_d = head_q;   tail_d = tail_q;   count_d = count_q;
      cm_valid_d = '0; cm_reg_d = '0; cm_tag_d = '0; cm_value_d = '0;
      cm_store_tag_d = TAG_W'(ZERO_ROB);
      fwd_ena_d = 1'b0; fwd_pc_d = '0; fwd_taken_d = 1'b0;
      misbranch_d = 1'b0; correct_addr_d = '0;
      n_commit = '0; ptag = '0; pidx = '0; cidx = '0; new_head_idx = '0;

      // Highest port first so the lowest-index port lands last and wins.
      for (int p = N_CDB - 1; p >= 0; p--) begin
         ptag = cdb_tag[p*TAG_W +: TAG_W];
         pidx = IDX_W'(ptag - TAG_W'(1));
         if (ptag != '0 && ptag <= TAG_W'(DEPTH) && meta_q[pidx].valid) begin
            meta_d[pidx].ready = 1'b1;
            data_d[pidx]       = cdb_value[p*DATA_W +: DATA_W];
            if (p == 0) begin
               meta_d[pidx].jump = cdb_isjump;
               jaddr_d[pidx]     = cdb_jump_addr;
            end
         end
      end

      for (int i = 0; i < COMMIT_W; i++) begin
         if (sel_mask[i]) begin
            n_commit                          = n_commit + TAG_W'(1);
            meta_d[lane_idx[i]].valid         = 1'b0;
            meta_d[lane_idx[i]].ready         = 1'b0;
            cm_valid_d[i]                     = 1'b1;
            cm_tag_d[i*TAG_W +: TAG_W]        = TAG_W'(lane_idx[i]) + TAG_W'(1);
            cm_value_d[i*DATA_W +: DATA_W]    = data_q[lane_idx[i]];
            if (lane_cls[i] == CLS_ALU || lane_cls[i] == CLS_JALR)
               cm_reg_d[i*REG_W +: REG_W] = dest_q[lane_idx[i]];
         end
      end
      if (store_hit)
         cm_store_tag_d = TAG_W'(lane_idx[store_lane]) + TAG_W'(1);
      if (ctrl_hit) begin
         cidx      = lane_idx[ctrl_lane];
         fwd_ena_d = 1'b1;
         fwd_pc_d  = pc_q[cidx];
         if (meta_q[cidx].cls == CLS_JALR) begin
            fwd_taken_d    = 1'b1;
            misbranch_d    = 1'b1;
            correct_addr_d = jaddr_q[cidx];
         end else begin
            fwd_taken_d = meta_q[cidx].jump;
            if (meta_q[cidx].jump != meta_q[cidx].pred) begin
               misbranch_d    = 1'b1;
               correct_addr_d = jaddr_q[cidx];
            end
         end
      end
      new_head_idx = head_idx + IDX_W'(n_commit);
      head_d       = TAG_W'(new_head_idx) + TAG_W'(1);

      if (alloc_fire) begin
         meta_d[tail_idx] = '{valid: 1'b1, ready: 1'b0, pred: alloc_pred_taken, jump: 1'b0,
                              cls: decode_op(alloc_inst[OP_RANGE-1:0])};
         dest_d[tail_idx]  = alloc_dest;
         pc_d[tail_idx]    = alloc_pc;
         jaddr_d[tail_idx] = '0;
         tail_d            = TAG_W'(wrap_inc(int'(tail_q), DEPTH));
      end
      count_d = count_q + TAG_W'(alloc_fire) - n_commit;

      if (misbranch_d) begin
         for (int k = 0; k < DEPTH; k++) begin
            meta_d[k].valid = 1'b0;
            meta_d[k].ready = 1'b0;
         end
         head_d  = TAG_W'(1);
         tail_d  = TAG_W'(1);
         count_d = '0;
      end
   end

   // Control state and output pulses; stall holds state and drops pulses.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) meta_q[k] <= '0;
         head_q <= TAG_W'(1); tail_q <= TAG_W'(1); count_q <= '0;
         cm_valid_q <= '0; cm_reg_q <= '0; cm_tag_q <= '0; cm_value_q <= '0;
         cm_store_tag_q <= '0; fwd_ena_q <= 1'b0; fwd_pc_q <= '0; fwd_taken_q <= 1'b0;
         misbranch_q <= 1'b0; correct_addr_q <= '0;
      end else if (ena) begin
         meta_q <= meta_d; head_q <= head_d; tail_q <= tail_d; count_q <= count_d;
         cm_valid_q <= cm_valid_d; cm_reg_q <= cm_reg_d; cm_tag_q <= cm_tag_d;
         cm_value_q <= cm_value_d; cm_store_tag_q <= cm_store_tag_d;
         fwd_ena_q <= fwd_ena_d; fwd_pc_q <= fwd_pc_d; fwd_taken_q <= fwd_taken_d;
         misbranch_q <= misbranch_d; correct_addr_q <= correct_addr_d;
      end else begin
         cm_valid_q <= '0; cm_reg_q <= '0; cm_tag_q <= '0; cm_value_q <= '0;
         cm_store_tag_q <= '0; fwd_ena_q <= 1'b0; fwd_pc_q <= '0; fwd_taken_q <= 1'b0;
         misbranch_q <= 1'b0; correct_addr_q <= '0;
      end
   end

   // Entry payload storage.
   always_ff @(posedge clk) begin
      // NOTE: payload arrays are not reset; the valid bits in meta_q gate every use.
      if (!rst && ena) begin
         dest_q <= dest_d; pc_q <= pc_d; jaddr_q <= jaddr_d; data_q <= data_d;
      end
   end

   // Operand queries with same-cycle CDB bypass (lowest port wins).
   always_comb begin
      q_ready1 = 1'b0; q_value1 = '0;
      q_ready2 = 1'b0; q_value2 = '0;
      for (int q = 0; q < 2; q++) begin
         logic [TAG_W-1:0]  qt;
         logic [IDX_W-1:0]  qi;
         logic              rdy;
         logic [DATA_W-1:0] val;
         qt  = (q == 0) ? q_tag1 : q_tag2;
         qi  = IDX_W'(qt - TAG_W'(1));
         rdy = 1'b0;
         val = '0;
         if (qt != '0 && qt <= TAG_W'(DEPTH) && meta_q[qi].valid) begin
            rdy = meta_q[qi].ready;
            val = meta_q[qi].ready ? data_q[qi] : '0;
            for (int p = N_CDB - 1; p >= 0; p--) begin
               if (cdb_tag[p*TAG_W +: TAG_W] == qt) begin
                  rdy = 1'b1;
                  val = cdb_value[p*DATA_W +: DATA_W];
               end
            end
         end
         if (q == 0) begin q_ready1 = rdy; q_value1 = val; end
         else        begin q_ready2 = rdy; q_value2 = val; end
      end
   end

   assign cm_valid     = cm_valid_q;
   assign cm_reg       = cm_reg_q;
   assign cm_tag       = cm_tag_q;
   assign cm_value     = cm_value_q;
   assign cm_store_tag = cm_store_tag_q;
   assign fwd_ena      = fwd_ena_q;
   assign fwd_pc       = fwd_pc_q;
   assign fwd_taken    = fwd_taken_q;
   assign misbranch    = misbranch_q;
   assign correct_addr = correct_addr_q;

endmodule
